// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = x - y - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  xs_q;
  logic [WIDTH-1:0]  ys_q;
  logic [WIDTH-1:0]  diff_q;
  logic              b_q;
  logic              bout_q;
  logic [CntW-1:0]   cnt_q;

  logic d_bit;
  logic b_next;
  logic last;

  // Single full-subtractor cell on the operand LSBs.
  assign d_bit  = xs_q[0] ^ ys_q[0] ^ b_q;
  assign b_next = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);
  assign last   = (cnt_q == CntW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic xm_q;
  logic ym_q;
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xm_q  <= 1'b0;
      ym_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == StIdle && in_valid) begin
        xm_q  <= x[WIDTH-1];
        ym_q  <= y[WIDTH-1];
        ovf_q <= 1'b0;
      end else if (state_q == StShift && last) begin
        // d_bit becomes diff[WIDTH-1] on this edge.
        ovf_q <= (xm_q ^ ym_q) & (xm_q ^ d_bit);
      end
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      xs_q    <= '0;
      ys_q    <= '0;
      diff_q  <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            xs_q    <= x;
            ys_q    <= y;
            b_q     <= bin;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            state_q <= StShift;
          end
        end
        StShift: begin
          b_q    <= b_next;
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          xs_q   <= {1'b0, xs_q[WIDTH-1:1]};
          ys_q   <= {1'b0, ys_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CntW'(1);
          if (last) begin
            bout_q  <= b_next;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StShift) || (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         ovf;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       b;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vecs[7];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive operands, let them be accepted, return at the negedge after the accept edge.
  task automatic start_op(input logic [7:0] xi, input logic [7:0] yi, input logic bi);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    x = xi; y = yi; bin = bi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  int lat;
  int n;
  int acc[4];
  logic seen;
  logic [7:0] bx[4];
  logic [7:0] by[4];
  logic       bb[4];
  logic [8:0] ref9;

  initial begin
    vecs[0] = '{x: 8'h5A, y: 8'h3C, b: 1'b0, d: 8'h1E, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{x: 8'h00, y: 8'h01, b: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{x: 8'h80, y: 8'h00, b: 1'b1, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[3] = '{x: 8'h00, y: 8'h80, b: 1'b1, d: 8'h7F, bo: 1'b1, ov: 1'b0};
    vecs[4] = '{x: 8'h10, y: 8'h01, b: 1'b0, d: 8'h0F, bo: 1'b0, ov: 1'b0};
    vecs[5] = '{x: 8'hFF, y: 8'hFF, b: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[6] = '{x: 8'h7F, y: 8'hFF, b: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].x, vecs[i].y, vecs[i].b);
      chk("shift_busy", busy, 1);
      chk("shift_in_ready", in_ready, 0);
      wait_done(lat);
      chk("latency", lat, W);
      chk("diff", diff, vecs[i].d);
      chk("bout", bout, vecs[i].bo);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", ovf, vecs[i].ov);
`endif
      @(negedge clk);
      chk("in_ready_after_hs", in_ready, 1);
      chk("out_valid_after_hs", out_valid, 0);
    end

    // Backpressure: result held while spurious operands are pulsed.
    out_ready = 1'b0;
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(lat);
    chk("bp_latency", lat, W);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      x = 8'hFF; y = 8'h00; bin = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, 8'h1E);
      chk("bp_bout", bout, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_not_accepted", busy, 0);
    chk("bp_diff_kept", diff, 8'h1E);

    // Asynchronous reset in the third SHIFT cycle.
    start_op(8'hFF, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      seen = seen | out_valid | busy;
    end
    chk("no_valid_after_rst", seen, 0);
    start_op(8'h10, 8'h01, 1'b0);
    wait_done(lat);
    chk("post_rst_diff", diff, 8'h0F);
    chk("post_rst_bout", bout, 0);
    @(negedge clk);

    // Back-to-back with in_valid held high.
    for (int k = 0; k < 4; k++) begin
      bx[k] = 8'($urandom);
      by[k] = 8'($urandom);
      bb[k] = 1'($urandom);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_idle_reached", in_ready, 1);
      acc[k] = cyc;
      x = bx[k]; y = by[k]; bin = bb[k];
      @(negedge clk);
      wait_done(lat);
      ref9 = {1'b0, bx[k]} - {1'b0, by[k]} - {8'h00, bb[k]};
      chk("b2b_latency", lat, W);
      chk("b2b_diff", diff, ref9[7:0]);
      chk("b2b_bout", bout, ref9[8]);
`ifdef SERIAL_SUB_OVF_EN
      chk("b2b_ovf", ovf, (bx[k][7] ^ by[k][7]) & (bx[k][7] ^ ref9[7]));
`endif
      if (k > 0) chk("b2b_period", acc[k] - acc[k-1], W + 2);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that computes diff = x − y − bin over WIDTH-bit operands using a single 1-bit full-subtractor cell, one bit per clock, LSB first. It accepts operands over a valid/ready handshake, owns the borrow register and the operand and result shift registers, and sequences the cell for exactly WIDTH cycles. The result is presented over a second valid/ready handshake. It is the area-optimised alternative to the ripple multi-bit subtractors in the subtractor library.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands x, y, bin valid.
- in_ready  out  1  block can accept operands; equals (state == IDLE).
- x  in  WIDTH  minuend.
- y  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  diff/bout valid; equals (state == DONE).
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  difference, registered.
- bout  out  1  borrow-out, registered.
- busy  out  1  high in SHIFT or DONE.
- ovf  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Accept: in_valid && in_ready at an edge.
  - Load xs <= x, ys <= y, b <= bin, cnt <= 0.
  - Clear diff.
  - Go to SHIFT.
- SHIFT, each edge:
  - d = xs[0] ^ ys[0] ^ b.
  - b <= (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b).
  - diff <= {d, diff[WIDTH-1:1]}.
  - xs, ys shift right by 1.
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH−1, go to DONE.
- cnt width is clog2(WIDTH) bits and never wraps during a valid operation.
- DONE:
  - diff holds the full result; bout = b.
  - Both are held stable until out_ready.
  - out_valid && out_ready at an edge -> IDLE.
- in_valid is ignored outside IDLE. x/y/bin need only be stable on the accept edge.
- No same-edge handover: after the result handshake, in_ready rises in the following cycle (IDLE).
- Arithmetic: diff = (x − y − bin) mod 2^WIDTH; bout = 1 iff x < y + bin (unsigned).
- Reset mid-operation (rst_n low in any state):
  - Immediately: state = IDLE; diff, bout, xs, ys, b, cnt = 0.
  - The operation is discarded.
  - No out_valid is produced for it.

## Timing
- Reset values: in_ready = 1, out_valid = 0, diff = 0, bout = 0, busy = 0, ovf = 0.
- Latency: with acceptance at edge E0, out_valid rises after edge E0+WIDTH (WIDTH cycles in SHIFT).
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- All outputs are driven from registers or decoded directly from state. There is no combinational path from in_valid/out_ready to any output.
- out_ready low in DONE: state, diff, bout and ovf are held indefinitely.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf is present.
  - Registered on the final SHIFT edge as (x[WIDTH-1] ^ y[WIDTH-1]) & (x[WIDTH-1] ^ diff[WIDTH-1]), using a latched copy of the operand MSBs.
  - Valid with out_valid; cleared on reset and on accept.
- SERIAL_SUB_OVF_EN undefined:
  - Port ovf and its MSB-capture registers are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then WIDTH=8, x=0x5A, y=0x3C, bin=0, out_ready=1:
  - out_valid rises exactly 8 cycles after accept.
  - Expect diff=0x1E, bout=0.
  - in_ready returns 1 one cycle after the result handshake.
- Underflow: x=0x00, y=0x01, bin=0 -> diff=0xFF, bout=1.
- Borrow-in: x=0x80, y=0x00, bin=1 -> diff=0x7F, bout=0.
  - With SERIAL_SUB_OVF_EN, ovf=1.
  - Repeat with x=0x00, y=0x80, bin=1 -> diff=0x7F, bout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with x=0xFF, y=0x00.
  - diff, bout and out_valid stay stable; in_ready stays 0.
  - The pulsed operands are never accepted.
- Reset mid-SHIFT: assert rst_n low during the 3rd SHIFT cycle.
  - All outputs go to 0 asynchronously.
  - After release, in_ready=1 and no out_valid appears.
  - A following x=0x10, y=0x01 yields diff=0x0F.
- Back-to-back: 4 random operand sets with out_ready=1 and in_valid held high.
  - Each result matches the (x−y−bin) reference model.
  - Each operation takes exactly WIDTH+2 cycles.
